fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Sequencer for the IF-stage program counter register. It merges redirect requests from trap, EX branch and ID jump, plus load-use and instruction-memory stalls.
- Drives the PC register's keep_pc, branch_op and branch_target inputs, and the IF/ID and ID/EX flush/stall controls.
- Buffers a redirect that arrives while instruction memory cannot accept a new fetch, and supports a halt/resume state.

Parameters:
XLEN, 32, address width of targets and PC.
PERF_W, 32, width of optional performance counters.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
trap_valid  input  1  trap/exception redirect request
trap_target  input  XLEN  trap handler address
ex_br_valid  input  1  taken branch / mispredict resolved in EX
ex_br_target  input  XLEN  EX redirect address
id_jmp_valid  input  1  jump decoded in ID
id_jmp_target  input  XLEN  ID jump address
load_use_hazard  input  1  ID instruction must wait one cycle
imem_ready  input  1  instruction memory accepts a new fetch address this cycle
halt_req  input  1  request to halt fetch; level, held until halted
resume  input  1  leave HALT
keep_pc  output  1  hold PC register
branch_op  output  1  load branch_target into PC
branch_target  output  XLEN  redirect address
flush_ifid  output  1  kill IF/ID contents
flush_idex  output  1  kill ID/EX contents
stall_ifid  output  1  hold IF/ID register
redirect_pending  output  1  redirect buffered, waiting on imem_ready
halted  output  1  controller in HALT

Behaviour:
- States: RUN, HOLD, HALT. Registered state plus pend_target (XLEN) and pend_src (NONE/JMP/BR/TRAP). Outputs are combinational from state and inputs.
- Reset while rst=1:
  - state=RUN, pend_target=0, pend_src=NONE.
  - Outputs forced to keep_pc=1, all other outputs 0.
  - Reset mid-HOLD or mid-HALT discards the pending redirect.
- Source select:
  - Priority is trap > ex_br > id_jmp.
  - id_jmp_valid is ignored while load_use_hazard=1.
  - sel_valid and sel_target denote the winner.
- Flushes, asserted in the cycle the winning request is seen, in RUN or HOLD:
  - trap or ex_br: flush_ifid=1 and flush_idex=1.
  - id_jmp: flush_ifid=1 only.
  - In HOLD, flush_ifid=1 every cycle.
- RUN:
  - sel_valid & imem_ready: branch_op=1, branch_target=sel_target, keep_pc=0, stall_ifid=0; stay RUN. The redirect takes effect in one cycle.
  - sel_valid & !imem_ready: keep_pc=1, branch_op=0; latch sel_target/src into pend; go to HOLD.
  - !sel_valid & halt_req: keep_pc=1; go to HALT.
  - Otherwise:
    - keep_pc = load_use_hazard | !imem_ready.
    - stall_ifid = load_use_hazard.
    - branch_op=0.
  - A trap or ex_br overrides load_use_hazard: stall_ifid=0 in that cycle.
- HOLD:
  - redirect_pending=1. keep_pc=1 and branch_op=0 until imem_ready.
  - New trap always overwrites pend. New ex_br overwrites pend only if pend_src is JMP or BR. id_jmp is ignored.
  - On imem_ready: branch_op=1, keep_pc=0, branch_target=pend_target; go to RUN. If an overriding request arrives in the same cycle, branch_target is the new target.
  - halt_req is ignored in HOLD.
- HALT:
  - halted=1, keep_pc=1, branch_op=0, flushes=0, stall_ifid=1.
  - All redirect requests are ignored.
  - resume=1 leaves to RUN on the next edge.
- branch_target is 0 whenever branch_op=0.

Optional Feature:
- Macro FETCH_REDIRECT_PERF_EN.
- When defined, adds two outputs:
  - perf_stall_cnt [PERF_W]: increments each non-reset cycle with keep_pc=1.
  - perf_redirect_cnt [PERF_W]: increments on each cycle with branch_op=1.
- Both counters wrap modulo 2^PERF_W and reset to 0.
- When not defined, these ports and registers are absent and there is no other change.

Test Plan:
- Reset for 3 cycles, then release with imem_ready=1 and no requests -> keep_pc=1 during reset; then keep_pc=0, branch_op=0, halted=0.
- ex_br_valid=1, target 0x0000_0100, imem_ready=1 -> same cycle branch_op=1, branch_target=0x100, flush_ifid=1, flush_idex=1.
- id_jmp 0x200 with imem_ready=0 for 3 cycles -> HOLD with keep_pc=1 and redirect_pending=1. A trap 0x80 arrives in cycle 2. On ready: branch_op=1, target=0x80.
- load_use_hazard=1 with ex_br 0x300 in the same cycle -> stall_ifid=0, branch_op=1, target=0x300. load_use_hazard alone -> keep_pc=1, stall_ifid=1.
- id_jmp 0x400 with load_use_hazard=1 -> jump ignored: branch_op=0, flush_ifid=0.
- halt_req=1 in RUN -> halted=1 next cycle, keep_pc=1. trap ignored while halted. resume=1 -> RUN. With FETCH_REDIRECT_PERF_EN, counters match the number of keep_pc and branch_op cycles.

Source files
------------

// File: rtl/fetch_redirect_if.sv
// Request/control bundle between the pipeline and the fetch redirect controller.
// Optional perf counter outputs exist only under FETCH_REDIRECT_PERF_EN.
interface fetch_redirect_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            ex_br_valid;
  logic [XLEN-1:0] ex_br_target;
  logic            id_jmp_valid;
  logic [XLEN-1:0] id_jmp_target;
  logic            load_use_hazard;
  logic            imem_ready;
  logic            halt_req;
  logic            resume;
  logic            keep_pc;
  logic            branch_op;
  logic [XLEN-1:0] branch_target;
  logic            flush_ifid;
  logic            flush_idex;
  logic            stall_ifid;
  logic            redirect_pending;
  logic            halted;
`ifdef FETCH_REDIRECT_PERF_EN
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_redirect_cnt;
`endif

  modport master (
    output trap_valid, trap_target, ex_br_valid, ex_br_target,
           id_jmp_valid, id_jmp_target, load_use_hazard, imem_ready,
           halt_req, resume,
`ifdef FETCH_REDIRECT_PERF_EN
    input  perf_stall_cnt, perf_redirect_cnt,
`endif
    input  keep_pc, branch_op, branch_target, flush_ifid, flush_idex,
           stall_ifid, redirect_pending, halted
  );

  modport slave (
    input  trap_valid, trap_target, ex_br_valid, ex_br_target,
           id_jmp_valid, id_jmp_target, load_use_hazard, imem_ready,
           halt_req, resume,
`ifdef FETCH_REDIRECT_PERF_EN
    output perf_stall_cnt, perf_redirect_cnt,
`endif
    output keep_pc, branch_op, branch_target, flush_ifid, flush_idex,
           stall_ifid, redirect_pending, halted
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// IF-stage PC sequencer: merges trap/branch/jump redirects and stalls, buffers a
// redirect while imem is busy, supports halt. FETCH_REDIRECT_PERF_EN adds counters.
module fetch_redirect_ctrl #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  fetch_redirect_if.slave bus
);
  typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_JMP, SRC_BR, SRC_TRAP} src_t;

  state_t          state, nxt_state;
  src_t            pend_src, nxt_src;
  logic [XLEN-1:0] pend_target, nxt_target;

  logic            jmp_ok, hard_req, sel_valid;
  src_t            sel_src;
  logic [XLEN-1:0] sel_target;
  logic            hold_ovr;
  src_t            ovr_src;
  logic [XLEN-1:0] ovr_target;

  logic            keep_pc, branch_op, flush_ifid, flush_idex, stall_ifid;
  logic            redirect_pending, halted;
  logic [XLEN-1:0] branch_target;

  // A jump decoded under a load-use hazard is not yet valid, so it never competes.
  assign jmp_ok   = bus.id_jmp_valid & ~bus.load_use_hazard;
  assign hard_req = bus.trap_valid | bus.ex_br_valid;
  assign sel_valid = hard_req | jmp_ok;

  always_comb begin
    sel_src    = SRC_NONE;
    sel_target = '0;
    if (bus.trap_valid) begin
      sel_src    = SRC_TRAP;
      sel_target = bus.trap_target;
    end else if (bus.ex_br_valid) begin
      sel_src    = SRC_BR;
      sel_target = bus.ex_br_target;
    end else if (jmp_ok) begin
      sel_src    = SRC_JMP;
      sel_target = bus.id_jmp_target;
    end
  end

  // While buffering, a trap always wins; an EX branch cannot displace a pending trap.
  assign hold_ovr   = bus.trap_valid |
                      (bus.ex_br_valid & (pend_src == SRC_JMP || pend_src == SRC_BR));
  assign ovr_src    = bus.trap_valid ? SRC_TRAP : SRC_BR;
  assign ovr_target = bus.trap_valid ? bus.trap_target : bus.ex_br_target;

  always_comb begin
    nxt_state        = state;
    nxt_src          = pend_src;
    nxt_target       = pend_target;
    keep_pc          = 1'b0;
    branch_op        = 1'b0;
    branch_target    = '0;
    flush_ifid       = 1'b0;
    flush_idex       = 1'b0;
    stall_ifid       = 1'b0;
    redirect_pending = 1'b0;
    halted           = 1'b0;
    case (state)
      RUN: begin
        flush_ifid = sel_valid;
        flush_idex = hard_req;
        stall_ifid = bus.load_use_hazard & ~hard_req;
        if (sel_valid && bus.imem_ready) begin
          branch_op     = 1'b1;
          branch_target = sel_target;
        end else if (sel_valid) begin
          keep_pc    = 1'b1;
          nxt_src    = sel_src;
          nxt_target = sel_target;
          nxt_state  = HOLD;
        end else if (bus.halt_req) begin
          keep_pc   = 1'b1;
          nxt_state = HALT;
        end else begin
          keep_pc = bus.load_use_hazard | ~bus.imem_ready;
        end
      end
      HOLD: begin
        redirect_pending = 1'b1;
        flush_ifid       = 1'b1;
        flush_idex       = hard_req;
        if (bus.imem_ready) begin
          branch_op     = 1'b1;
          branch_target = hold_ovr ? ovr_target : pend_target;
          nxt_src       = SRC_NONE;
          nxt_state     = RUN;
        end else begin
          keep_pc = 1'b1;
          if (hold_ovr) begin
            nxt_src    = ovr_src;
            nxt_target = ovr_target;
          end
        end
      end
      HALT: begin
        halted     = 1'b1;
        keep_pc    = 1'b1;
        stall_ifid = 1'b1;
        if (bus.resume) nxt_state = RUN;
      end
      default: begin
        keep_pc   = 1'b1;
        nxt_state = RUN;
        nxt_src   = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pend_src    <= SRC_NONE;
      pend_target <= '0;
    end else begin
      state       <= nxt_state;
      pend_src    <= nxt_src;
      pend_target <= nxt_target;
    end
  end

  // Reset holds the PC and silences every other control.
  assign bus.keep_pc          = rst | keep_pc;
  assign bus.branch_op        = ~rst & branch_op;
  assign bus.branch_target    = rst ? '0 : branch_target;
  assign bus.flush_ifid       = ~rst & flush_ifid;
  assign bus.flush_idex       = ~rst & flush_idex;
  assign bus.stall_ifid       = ~rst & stall_ifid;
  assign bus.redirect_pending = ~rst & redirect_pending;
  assign bus.halted           = ~rst & halted;

`ifdef FETCH_REDIRECT_PERF_EN
  logic [PERF_W-1:0] perf_stall_cnt, perf_redirect_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (keep_pc)   perf_stall_cnt    <= perf_stall_cnt + 1'b1;
      if (branch_op) perf_redirect_cnt <= perf_redirect_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cnt    = perf_stall_cnt;
  assign bus.perf_redirect_cnt = perf_redirect_cnt;
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: each task drives one scenario and checks
// the combinational controls mid-cycle against hand-computed values.
module tb_fetch_redirect_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_if #(.XLEN(32), .PERF_W(32)) bus ();

  fetch_redirect_ctrl #(.XLEN(32), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.trap_valid      = 1'b0;
    bus.trap_target     = '0;
    bus.ex_br_valid     = 1'b0;
    bus.ex_br_target    = '0;
    bus.id_jmp_valid    = 1'b0;
    bus.id_jmp_target   = '0;
    bus.load_use_hazard = 1'b0;
    bus.imem_ready      = 1'b1;
    bus.halt_req        = 1'b0;
    bus.resume          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr();
    bus.ex_br_valid  = 1'b1;
    bus.ex_br_target = 32'h0000_0abc;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.keep_pc !== 1'b1 || bus.branch_op !== 1'b0 || bus.flush_ifid !== 1'b0 ||
          bus.branch_target !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: keep=%b br=%b fl=%b tgt=%h, want keep=1 br=0 fl=0 tgt=0",
                 i, bus.keep_pc, bus.branch_op, bus.flush_ifid, bus.branch_target);
      end
    end
    clr();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.keep_pc !== 1'b0 || bus.branch_op !== 1'b0 || bus.halted !== 1'b0 ||
        bus.redirect_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: keep=%b br=%b halted=%b pend=%b, want all 0",
               bus.keep_pc, bus.branch_op, bus.halted, bus.redirect_pending);
    end
    step();
  endtask

  task automatic test_ex_branch();
    bus.ex_br_valid  = 1'b1;
    bus.ex_br_target = 32'h0000_0100;
    #1;
    checks++;
    if (bus.branch_op !== 1'b1 || bus.branch_target !== 32'h100 || bus.keep_pc !== 1'b0 ||
        bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL ex_branch: br=%b tgt=%h keep=%b fi=%b fx=%b, want 1 100 0 1 1",
               bus.branch_op, bus.branch_target, bus.keep_pc, bus.flush_ifid, bus.flush_idex);
    end
    step();
    clr();
  endtask

  task automatic test_hold_trap_override();
    bus.id_jmp_valid  = 1'b1;
    bus.id_jmp_target = 32'h200;
    bus.imem_ready    = 1'b0;
    #1;
    checks++;
    if (bus.keep_pc !== 1'b1 || bus.branch_op !== 1'b0 || bus.flush_ifid !== 1'b1 ||
        bus.flush_idex !== 1'b0) begin
      errors++;
      $display("FAIL hold_enter: keep=%b br=%b fi=%b fx=%b, want 1 0 1 0",
               bus.keep_pc, bus.branch_op, bus.flush_ifid, bus.flush_idex);
    end
    step();
    bus.id_jmp_valid = 1'b0;
    bus.trap_valid   = 1'b1;
    bus.trap_target  = 32'h80;
    #1;
    checks++;
    if (bus.redirect_pending !== 1'b1 || bus.keep_pc !== 1'b1 || bus.branch_op !== 1'b0 ||
        bus.flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL hold_trap: pend=%b keep=%b br=%b fx=%b, want 1 1 0 1",
               bus.redirect_pending, bus.keep_pc, bus.branch_op, bus.flush_idex);
    end
    step();
    bus.trap_valid = 1'b0;
    #1;
    checks++;
    if (bus.redirect_pending !== 1'b1 || bus.keep_pc !== 1'b1 || bus.flush_ifid !== 1'b1 ||
        bus.branch_target !== 32'h0) begin
      errors++;
      $display("FAIL hold_wait: pend=%b keep=%b fi=%b tgt=%h, want 1 1 1 0",
               bus.redirect_pending, bus.keep_pc, bus.flush_ifid, bus.branch_target);
    end
    step();
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if (bus.branch_op !== 1'b1 || bus.branch_target !== 32'h80 || bus.keep_pc !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: br=%b tgt=%h keep=%b, want 1 80 0",
               bus.branch_op, bus.branch_target, bus.keep_pc);
    end
    step();
    clr();
    #1;
    checks++;
    if (bus.redirect_pending !== 1'b0 || bus.keep_pc !== 1'b0) begin
      errors++;
      $display("FAIL hold_back_to_run: pend=%b keep=%b, want 0 0",
               bus.redirect_pending, bus.keep_pc);
    end
  endtask

  task automatic test_hold_priority();
    // pending trap must survive a later EX branch
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h90;
    bus.imem_ready  = 1'b0;
    step();
    clr();
    bus.ex_br_valid  = 1'b1;
    bus.ex_br_target = 32'ha0;
    #1;
    checks++;
    if (bus.branch_op !== 1'b1 || bus.branch_target !== 32'h90) begin
      errors++;
      $display("FAIL hold_trap_kept: br=%b tgt=%h, want 1 90", bus.branch_op, bus.branch_target);
    end
    step();
    clr();
    // pending jump is displaced by a same-cycle EX branch on release
    bus.id_jmp_valid  = 1'b1;
    bus.id_jmp_target = 32'h500;
    bus.imem_ready    = 1'b0;
    step();
    clr();
    bus.halt_req     = 1'b1;
    bus.imem_ready   = 1'b0;
    bus.id_jmp_valid = 1'b1;
    bus.id_jmp_target = 32'h555;
    step();
    bus.id_jmp_valid = 1'b0;
    bus.halt_req     = 1'b0;
    bus.ex_br_valid  = 1'b1;
    bus.ex_br_target = 32'h600;
    bus.imem_ready   = 1'b1;
    #1;
    checks++;
    if (bus.branch_op !== 1'b1 || bus.branch_target !== 32'h600 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL hold_br_override: br=%b tgt=%h halted=%b, want 1 600 0",
               bus.branch_op, bus.branch_target, bus.halted);
    end
    step();
    clr();
  endtask

  task automatic test_load_use();
    bus.load_use_hazard = 1'b1;
    bus.ex_br_valid     = 1'b1;
    bus.ex_br_target    = 32'h300;
    #1;
    checks++;
    if (bus.stall_ifid !== 1'b0 || bus.branch_op !== 1'b1 || bus.branch_target !== 32'h300) begin
      errors++;
      $display("FAIL load_use_br: stall=%b br=%b tgt=%h, want 0 1 300",
               bus.stall_ifid, bus.branch_op, bus.branch_target);
    end
    step();
    bus.ex_br_valid = 1'b0;
    #1;
    checks++;
    if (bus.keep_pc !== 1'b1 || bus.stall_ifid !== 1'b1 || bus.branch_op !== 1'b0) begin
      errors++;
      $display("FAIL load_use_only: keep=%b stall=%b br=%b, want 1 1 0",
               bus.keep_pc, bus.stall_ifid, bus.branch_op);
    end
    step();
    bus.id_jmp_valid  = 1'b1;
    bus.id_jmp_target = 32'h400;
    #1;
    checks++;
    if (bus.branch_op !== 1'b0 || bus.flush_ifid !== 1'b0 || bus.branch_target !== 32'h0 ||
        bus.keep_pc !== 1'b1) begin
      errors++;
      $display("FAIL jmp_masked: br=%b fi=%b tgt=%h keep=%b, want 0 0 0 1",
               bus.branch_op, bus.flush_ifid, bus.branch_target, bus.keep_pc);
    end
    step();
    clr();
    #1;
    checks++;
    if (bus.redirect_pending !== 1'b0 || bus.keep_pc !== 1'b0) begin
      errors++;
      $display("FAIL jmp_masked_after: pend=%b keep=%b, want 0 0",
               bus.redirect_pending, bus.keep_pc);
    end
  endtask

  task automatic test_halt();
    bus.halt_req = 1'b1;
    #1;
    checks++;
    if (bus.keep_pc !== 1'b1 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_req: keep=%b halted=%b, want 1 0", bus.keep_pc, bus.halted);
    end
    step();
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h80;
    #1;
    checks++;
    if (bus.halted !== 1'b1 || bus.keep_pc !== 1'b1 || bus.stall_ifid !== 1'b1 ||
        bus.branch_op !== 1'b0 || bus.flush_ifid !== 1'b0 || bus.flush_idex !== 1'b0) begin
      errors++;
      $display("FAIL halted_trap: halted=%b keep=%b stall=%b br=%b fi=%b fx=%b, want 1 1 1 0 0 0",
               bus.halted, bus.keep_pc, bus.stall_ifid, bus.branch_op, bus.flush_ifid,
               bus.flush_idex);
    end
    step();
    clr();
    bus.resume = 1'b1;
    #1;
    checks++;
    if (bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL resume_cycle: halted=%b, want 1", bus.halted);
    end
    step();
    bus.resume = 1'b0;
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.keep_pc !== 1'b0 || bus.redirect_pending !== 1'b0) begin
      errors++;
      $display("FAIL resumed: halted=%b keep=%b pend=%b, want 0 0 0",
               bus.halted, bus.keep_pc, bus.redirect_pending);
    end
    step();
  endtask

  task automatic test_reset_mid_hold();
    bus.id_jmp_valid  = 1'b1;
    bus.id_jmp_target = 32'h700;
    bus.imem_ready    = 1'b0;
    step();
    clr();
    bus.imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.redirect_pending !== 1'b0 || bus.keep_pc !== 1'b1 || bus.flush_ifid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_hold: pend=%b keep=%b fi=%b, want 0 1 0",
               bus.redirect_pending, bus.keep_pc, bus.flush_ifid);
    end
    step();
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if (bus.branch_op !== 1'b0 || bus.redirect_pending !== 1'b0 || bus.keep_pc !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard: br=%b pend=%b keep=%b, want 0 0 0",
               bus.branch_op, bus.redirect_pending, bus.keep_pc);
    end
    step();
  endtask

`ifdef FETCH_REDIRECT_PERF_EN
  task automatic test_perf();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();                         // idle: no count
    bus.load_use_hazard = 1'b1;
    step();                         // stall 1
    step();                         // stall 2
    bus.load_use_hazard = 1'b0;
    bus.ex_br_valid     = 1'b1;
    bus.ex_br_target    = 32'h44;
    step();                         // redirect 1
    bus.ex_br_valid = 1'b0;
    bus.imem_ready  = 1'b0;
    step();                         // stall 3
    clr();
    #1;
    checks++;
    if (bus.perf_stall_cnt !== 32'd3 || bus.perf_redirect_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts: stall=%0d redir=%0d, want 3 1",
               bus.perf_stall_cnt, bus.perf_redirect_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ex_branch();
    test_hold_trap_override();
    test_hold_priority();
    test_load_use();
    test_halt();
    test_reset_mid_hold();
`ifdef FETCH_REDIRECT_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
